dwc_window_reorder: RTL and testbench

//  Width-converting reorder buffer between a sliding-window generator and an MVAU/VVAU.

---
 rtl/dwc_window_reorder.sv | 166 ++++++++++++++++
 tb/tb_dwc_window_reorder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwc_window_reorder.sv
// Ping-pong window buffer that re-slices one [KERNEL_PROD][CHANNELS] window
// into NF*SF beats of [SIMD][PE] activations, with selectable fold order and tlast.
module dwc_window_reorder #(
  parameter int SIMD             = 3,
  parameter int PE               = 2,
  parameter int CHANNELS         = 9,
  parameter int KERNEL_PROD      = 4,
  parameter int ACTIVATION_WIDTH = 4,
  parameter int SF_OUTER         = 0,
  localparam int SF              = CHANNELS / SIMD,
  localparam int NF              = KERNEL_PROD / PE,
  localparam int BEATS           = SF * NF,
  localparam int IW              = KERNEL_PROD * CHANNELS * ACTIVATION_WIDTH,
  localparam int OW              = SIMD * PE * ACTIVATION_WIDTH
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic [IW-1:0] s_axis_input_tdata,
  input  logic          s_axis_input_tvalid,
  output logic          s_axis_input_tready,
  output logic [OW-1:0] m_axis_output_tdata,
  output logic          m_axis_output_tvalid,
  input  logic          m_axis_output_tready,
  output logic          m_axis_output_tlast
);

  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
  localparam int CW  = (SFW > NFW) ? SFW : NFW;
  localparam logic [CW-1:0] SF_MAX = CW'(SF - 1);
  localparam logic [CW-1:0] NF_MAX = CW'(NF - 1);

  if ((CHANNELS % SIMD) != 0) begin : g_bad_simd
    $fatal(1, "dwc_window_reorder: CHANNELS must be a multiple of SIMD");
  end
  if ((KERNEL_PROD % PE) != 0) begin : g_bad_pe
    $fatal(1, "dwc_window_reorder: KERNEL_PROD must be a multiple of PE");
  end
  if (BEATS < 1) begin : g_bad_beats
    $fatal(1, "dwc_window_reorder: fold produces no beats");
  end

  logic [IW-1:0] bank0_q, bank0_d;
  logic [IW-1:0] bank1_q, bank1_d;
  logic [1:0]    occ_q, occ_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] nf_q, nf_d;
  logic [CW-1:0] sf_q, sf_d;

  logic          accept_s;
  logic          fire_s;
  logic          last_beat_s;
  logic          release_s;
  logic [IW-1:0] rd_win_s;
  logic [OW-1:0] beat_s;

  // Handshake decode; the input may be accepted in the very cycle a full bank is released.
  always_comb begin
    m_axis_output_tvalid = (occ_q != 2'd0);
    fire_s               = m_axis_output_tvalid && m_axis_output_tready;
    last_beat_s          = (nf_q == NF_MAX) && (sf_q == SF_MAX);
    release_s            = fire_s && last_beat_s;
    s_axis_input_tready  = ap_rst_n && ((occ_q < 2'd2) || release_s);
    accept_s             = s_axis_input_tvalid && s_axis_input_tready;
  end

  // Beat mux: element [s][p] comes from kernel position nf*PE+p, channel sf*SIMD+s.
  always_comb begin
    rd_win_s = rd_ptr_q ? bank1_q : bank0_q;
    beat_s   = '0;
    for (int s = 0; s < SIMD; s++) begin
      for (int p = 0; p < PE; p++) begin
        beat_s[(s*PE + p)*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] =
          rd_win_s[((int'(nf_q)*PE + p)*CHANNELS + int'(sf_q)*SIMD + s)*ACTIVATION_WIDTH +: ACTIVATION_WIDTH];
      end
    end
    if (m_axis_output_tvalid) begin
      m_axis_output_tdata = beat_s;
      m_axis_output_tlast = last_beat_s;
    end else begin
      m_axis_output_tdata = '0;
      m_axis_output_tlast = 1'b0;
    end
  end

  // Bank write, pointer toggling and occupancy bookkeeping.
  always_comb begin
    bank0_d  = bank0_q;
    bank1_d  = bank1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (accept_s) begin
      wr_ptr_d = ~wr_ptr_q;
      if (wr_ptr_q) begin
        bank1_d = s_axis_input_tdata;
      end else begin
        bank0_d = s_axis_input_tdata;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (release_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, release_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Fold counters; the inner loop is sf when SF_OUTER==0 and nf otherwise.
  always_comb begin
    nf_d = nf_q;
    sf_d = sf_q;
    if (fire_s) begin
      if (last_beat_s) begin
        nf_d = '0;
        sf_d = '0;
      end else if (SF_OUTER != 0) begin
        if (nf_q == NF_MAX) begin
          nf_d = '0;
          sf_d = sf_q + CW'(1);
        end else begin
          nf_d = nf_q + CW'(1);
        end
      end else begin
        if (sf_q == SF_MAX) begin
          sf_d = '0;
          nf_d = nf_q + CW'(1);
        end else begin
          sf_d = sf_q + CW'(1);
        end
      end
    end else begin
      nf_d = nf_q;
      sf_d = sf_q;
    end
  end

  // State registers; reset discards any buffered windows.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      bank0_q  <= '0;
      bank1_q  <= '0;
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      nf_q     <= '0;
      sf_q     <= '0;
    end else begin
      bank0_q  <= bank0_d;
      bank1_q  <= bank1_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      nf_q     <= nf_d;
      sf_q     <= sf_d;
    end
  end

endmodule

// File: tb/tb_dwc_window_reorder.sv
// Scoreboard bench for dwc_window_reorder: default instance, SF_OUTER=1 instance,
// and two parameter-sweep instances (BEATS=36 and BEATS=1).
module tb_dwc_window_reorder;

  typedef struct {
    logic [143:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [143:0] s0_data = '0, s1_data = '0, s2_data = '0, s3_data = '0;
  logic s0_valid = 1'b0, s1_valid = 1'b0, s2_valid = 1'b0, s3_valid = 1'b0;
  logic s0_ready, s1_ready, s2_ready, s3_ready;
  logic m0_ready = 1'b1, m1_ready = 1'b1, m2_ready = 1'b1, m3_ready = 1'b1;
  logic m0_valid, m1_valid, m2_valid, m3_valid;
  logic m0_last, m1_last, m2_last, m3_last;
  logic [23:0]  m0_data, m1_data;
  logic [3:0]   m2_data;
  logic [143:0] m3_data;

  dwc_window_reorder u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_input_tdata(s0_data), .s_axis_input_tvalid(s0_valid), .s_axis_input_tready(s0_ready),
    .m_axis_output_tdata(m0_data), .m_axis_output_tvalid(m0_valid),
    .m_axis_output_tready(m0_ready), .m_axis_output_tlast(m0_last));

  dwc_window_reorder #(.SF_OUTER(1)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_input_tdata(s1_data), .s_axis_input_tvalid(s1_valid), .s_axis_input_tready(s1_ready),
    .m_axis_output_tdata(m1_data), .m_axis_output_tvalid(m1_valid),
    .m_axis_output_tready(m1_ready), .m_axis_output_tlast(m1_last));

  dwc_window_reorder #(.SIMD(1), .PE(1), .CHANNELS(4), .KERNEL_PROD(9)) u_dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_input_tdata(s2_data), .s_axis_input_tvalid(s2_valid), .s_axis_input_tready(s2_ready),
    .m_axis_output_tdata(m2_data), .m_axis_output_tvalid(m2_valid),
    .m_axis_output_tready(m2_ready), .m_axis_output_tlast(m2_last));

  dwc_window_reorder #(.SIMD(9), .PE(4)) u_dut3 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_input_tdata(s3_data), .s_axis_input_tvalid(s3_valid), .s_axis_input_tready(s3_ready),
    .m_axis_output_tdata(m3_data), .m_axis_output_tvalid(m3_valid),
    .m_axis_output_tready(m3_ready), .m_axis_output_tlast(m3_last));

  int errors = 0;
  int checks = 0;
  exp_t q0[$], q1[$], q2[$], q3[$];
  exp_t e0, e1, e2, e3;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [143:0] pat(input int seed);
    logic [143:0] w = '0;
    for (int e = 0; e < 36; e++) w[e*4 +: 4] = 4'((e + seed) % 16);
    return w;
  endfunction

  function automatic logic [143:0] rnd_win();
    logic [143:0] w = '0;
    for (int i = 0; i < 18; i++) w[i*8 +: 8] = 8'($urandom());
    return w;
  endfunction

  // Golden slice: beat element [s][p] = window[nf*pe+p][sf*simd+s]
  function automatic logic [143:0] model(input logic [143:0] w, input int ch, input int simd,
                                         input int pe, input int nf, input int sf);
    logic [143:0] r = '0;
    for (int s = 0; s < simd; s++)
      for (int p = 0; p < pe; p++)
        r[(s*pe + p)*4 +: 4] = w[((nf*pe + p)*ch + sf*simd + s)*4 +: 4];
    return r;
  endfunction

  task automatic push(input int inst, input logic [143:0] w);
    int ch, simd, pe, kp, so, sfn, nfn, nf, sf;
    exp_t e;
    case (inst)
      1:       begin ch = 9; simd = 3; pe = 2; kp = 4; so = 1; end
      2:       begin ch = 4; simd = 1; pe = 1; kp = 9; so = 0; end
      3:       begin ch = 9; simd = 9; pe = 4; kp = 4; so = 0; end
      default: begin ch = 9; simd = 3; pe = 2; kp = 4; so = 0; end
    endcase
    sfn = ch / simd;
    nfn = kp / pe;
    for (int o = 0; o < (so != 0 ? sfn : nfn); o++) begin
      for (int i = 0; i < (so != 0 ? nfn : sfn); i++) begin
        nf = (so != 0) ? i : o;
        sf = (so != 0) ? o : i;
        e.data = model(w, ch, simd, pe, nf, sf);
        e.last = (nf == nfn - 1) && (sf == sfn - 1);
        case (inst)
          1:       q1.push_back(e);
          2:       q2.push_back(e);
          3:       q3.push_back(e);
          default: q0.push_back(e);
        endcase
      end
    end
  endtask

  task automatic send(input int inst, input logic [143:0] w);
    logic acc = 1'b0;
    int n = 0;
    push(inst, w);
    case (inst)
      1:       begin s1_data = w; s1_valid = 1'b1; end
      2:       begin s2_data = w; s2_valid = 1'b1; end
      3:       begin s3_data = w; s3_valid = 1'b1; end
      default: begin s0_data = w; s0_valid = 1'b1; end
    endcase
    while (!acc && n < 500) begin
      @(negedge clk);
      case (inst)
        1:       acc = s1_ready;
        2:       acc = s2_ready;
        3:       acc = s3_ready;
        default: acc = s0_ready;
      endcase
      @(posedge clk); #1;
      n++;
    end
    s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0; s3_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: inst %0d got no ready, expected accept", inst);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if ((q0.size() + q1.size() + q2.size() + q3.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0",
               q0.size() + q1.size() + q2.size() + q3.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Default-instance monitor: scoreboard compare plus hold-while-stalled check.
  logic         p0_stall = 1'b0;
  logic [23:0]  p0_data = '0;
  logic         p0_last = 1'b0;
  always @(negedge clk) begin
    if (rst_n && p0_stall) begin
      chk("stall_valid", 144'(m0_valid), 144'd1);
      chk("stall_data", 144'(m0_data), 144'(p0_data));
      chk("stall_last", 144'(m0_last), 144'(p0_last));
    end
    p0_stall = rst_n && m0_valid && !m0_ready;
    p0_data  = m0_data;
    p0_last  = m0_last;
    if (rst_n && m0_valid && m0_ready) begin
      if (q0.size() == 0) chk("dut0_unexpected_beat", 144'd1, 144'd0);
      else begin
        e0 = q0.pop_front();
        chk("dut0_data", 144'(m0_data), e0.data);
        chk("dut0_last", 144'(m0_last), 144'(e0.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m1_valid && m1_ready) begin
      if (q1.size() == 0) chk("dut1_unexpected_beat", 144'd1, 144'd0);
      else begin
        e1 = q1.pop_front();
        chk("dut1_data", 144'(m1_data), e1.data);
        chk("dut1_last", 144'(m1_last), 144'(e1.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m2_valid && m2_ready) begin
      if (q2.size() == 0) chk("dut2_unexpected_beat", 144'd1, 144'd0);
      else begin
        e2 = q2.pop_front();
        chk("dut2_data", 144'(m2_data), e2.data);
        chk("dut2_last", 144'(m2_last), 144'(e2.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m3_valid && m3_ready) begin
      if (q3.size() == 0) chk("dut3_unexpected_beat", 144'd1, 144'd0);
      else begin
        e3 = q3.pop_front();
        chk("dut3_data", m3_data, e3.data);
        chk("dut3_last", 144'(m3_last), 144'(e3.last));
      end
    end
  end

  logic       rnd_done = 1'b0;
  logic       hs;
  logic [6:0] exp_rdy;
  int         acc_n, vcnt, first_v, last_v;

  initial begin
    #1;
    chk("reset_s_tready", 144'(s0_ready), 144'd0);
    chk("reset_m_tvalid", 144'(m0_valid), 144'd0);
    chk("reset_m_tlast", 144'(m0_last), 144'd0);
    chk("reset_m_tdata", 144'(m0_data), 144'd0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_tready", 144'(s0_ready), 144'd1);

    // Test 1: nf-outer order, hand-computed elements and tlast position
    send(0, pat(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_valid", 144'(m0_valid), 144'd1);
      chk("t1_last", 144'(m0_last), (i == 5) ? 144'd1 : 144'd0);
      if (i == 0) chk("t1_b00_e01", 144'(m0_data[7:4]), 144'd9);
      if (i == 5) begin
        chk("t1_b12_e00", 144'(m0_data[3:0]), 144'd8);
        chk("t1_b12_e11", 144'(m0_data[15:12]), 144'd2);
      end
    end
    drain();

    // Test 2: sf-outer order on the second instance
    send(1, pat(0));
    send(1, pat(3));
    drain();

    // Test 3: three back-to-back windows, no output gaps, ready timing around release
    exp_rdy = 7'b1000011;
    acc_n = 0; vcnt = 0; first_v = -1; last_v = -1;
    s0_data = pat(10); push(0, pat(10)); s0_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c < 7) chk("t3_s_tready", 144'(s0_ready), 144'(exp_rdy[c]));
      if (m0_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        vcnt++;
      end
      hs = s0_valid && s0_ready;
      @(posedge clk); #1;
      if (hs) begin
        acc_n++;
        if (acc_n < 3) begin
          s0_data = pat(10 + acc_n);
          push(0, pat(10 + acc_n));
        end else s0_valid = 1'b0;
      end
    end
    chk("t3_valid_count", 144'(vcnt), 144'd18);
    chk("t3_contiguous", 144'(last_v - first_v + 1), 144'd18);
    drain();

    // Test 4: random backpressure and input gaps
    fork
      begin
        for (int w = 0; w < 50; w++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(0, rnd_win());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m0_ready = ($urandom_range(0, 99) >= 40);
        end
        m0_ready = 1'b1;
      end
    join
    drain();

    // Test 5: asynchronous reset after the third beat of a window
    m0_ready = 1'b0;
    send(0, pat(4));
    m0_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 144'(m0_valid), 144'd0);
    chk("t5_rst_last", 144'(m0_last), 144'd0);
    chk("t5_rst_data", 144'(m0_data), 144'd0);
    chk("t5_rst_s_tready", 144'(s0_ready), 144'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, pat(6));
    drain();

    // Test 6: parameter sweep instances (BEATS=36, BEATS=1 skid FIFO)
    send(2, pat(5));
    send(2, pat(7));
    drain();
    m3_ready = 1'b0;
    send(3, pat(1));
    send(3, pat(2));
    @(negedge clk);
    chk("t6_full_s_tready", 144'(s3_ready), 144'd0);
    @(posedge clk); #1;
    m3_ready = 1'b1;
    send(3, pat(9));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
